// File: rtl/rv_sched_pkg.sv
// Shared definitions for the hart time-slice scheduler.
//   sched_state_t : FSM state encoding (IDLE=0, RUN=1, DRAIN=2, FLUSH=3),
//                   also visible on the scheduler's r_state debug output.
//   sel_width()   : width of a hart index; never narrower than one bit so a
//                   single-hart cluster still has a legal select bus.
package rv_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } sched_state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_rr_pick.sv
// Wrapping priority finder used for next-hart selection.
// Starting at index 'start' and wrapping modulo N, returns the first index
// whose enable bit is set.
//   en    in  N      candidate enables
//   start in  SEL_W  first index examined (must be < N)
//   found out 1      at least one enable bit is set
//   idx   out SEL_W  selected index (equals start when nothing is found)
module rv_rr_pick #(
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic [N-1:0]     en,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    int cand;

    // Walk from the farthest candidate back to 'start' so the nearest
    // enabled index is the last one written and therefore wins.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(start) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (cand < N) begin
                if (en[cand]) begin
                    found = 1'b1;
                    idx   = SEL_W'(cand);
                end
            end
        end
    end

endmodule

// File: rtl/rv_hart_scheduler.sv
// Time-slice scheduler for the multi-hart RV cluster. Chooses which hart owns
// the shared memory port / MMU, guarantees each slice at least QUANTUM cycles,
// only hands over at a safe instruction boundary, and funnels TLB-flush
// requests from every hart into single flush handshakes with the MMU.
//   CLK           in   clock
//   RST_X         in   asynchronous active-low reset
//   w_hart_en     in   hart eligible to run
//   w_switch_ok   in   hart is at a safe switch boundary
//   w_mem_busy    in   shared memory/MMU transaction in flight
//   w_flush_req   in   per-hart TLB-flush request pulse
//   w_flush_done  in   MMU flush complete pulse
//   r_hart_sel    out  selected hart index
//   r_sel_valid   out  selected hart is running (RUN or DRAIN)
//   r_switch      out  pulse in the first cycle a new hart is selected
//   r_flush       out  flush request level to the MMU
//   r_stall       out  per-hart stall (0 only for the running hart)
//   r_quantum_cnt out  cycles used in the current slice
//   r_state       out  FSM state (debug)
//
// MMU flush handshake: r_flush is a level that rises only when no memory
// transaction is in flight and stays high until w_flush_done is sampled high
// on a clock edge; r_flush falls on that same edge. w_flush_done seen while
// r_flush is low carries no meaning and is ignored.
module rv_hart_scheduler
    import rv_sched_pkg::*;
#(
    parameter int N_HARTS = 2,
    parameter int QUANTUM = 1024,
    parameter int SEL_W   = sel_width(N_HARTS),
    parameter int CNT_W   = $clog2(QUANTUM + 1)
) (
    input  logic               CLK,
    input  logic               RST_X,
    input  logic [N_HARTS-1:0] w_hart_en,
    input  logic [N_HARTS-1:0] w_switch_ok,
    input  logic               w_mem_busy,
    input  logic [N_HARTS-1:0] w_flush_req,
    input  logic               w_flush_done,
    output logic [SEL_W-1:0]   r_hart_sel,
    output logic               r_sel_valid,
    output logic               r_switch,
    output logic               r_flush,
    output logic [N_HARTS-1:0] r_stall,
    output logic [CNT_W-1:0]   r_quantum_cnt,
    output logic [1:0]         r_state
);

    sched_state_t     state;
    sched_state_t     ret_state;
    logic             flush_pend;
    logic             cur_en;
    logic             cur_ok;
    logic [SEL_W-1:0] sel_plus1;
    logic [SEL_W-1:0] pick_start;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             expire;
    logic             enter_flush;
    logic             drain_go;
    logic [CNT_W-1:0] cnt_inc;

    // Stall vector with only hart 's' released.
    function automatic logic [N_HARTS-1:0] run_mask(input logic [SEL_W-1:0] s);
        logic [N_HARTS-1:0] m;
        m = '1;
        for (int g = 0; g < N_HARTS; g++) begin
            if (SEL_W'(g) == s) begin
                m[g] = 1'b0;
            end
        end
        return m;
    endfunction

    always_comb begin
        cur_en = 1'b0;
        cur_ok = 1'b0;
        for (int g = 0; g < N_HARTS; g++) begin
            if (SEL_W'(g) == r_hart_sel) begin
                cur_en = w_hart_en[g];
                cur_ok = w_switch_ok[g];
            end
        end
    end

    // In DRAIN the search starts after the current hart so it is considered
    // last; from IDLE the current index is preferred.
    assign sel_plus1   = (r_hart_sel == SEL_W'(N_HARTS - 1)) ? '0 : r_hart_sel + SEL_W'(1);
    assign pick_start  = (state == ST_DRAIN) ? sel_plus1 : r_hart_sel;
    assign expire      = (r_quantum_cnt >= CNT_W'(QUANTUM - 1));
    assign cnt_inc     = (r_quantum_cnt >= CNT_W'(QUANTUM)) ? r_quantum_cnt
                                                           : r_quantum_cnt + CNT_W'(1);
    assign enter_flush = flush_pend && ((state == ST_RUN) || (state == ST_DRAIN));
    assign drain_go    = (cur_ok || !cur_en) && !w_mem_busy;
    assign r_state     = state;

    rv_rr_pick #(
        .N     (N_HARTS),
        .SEL_W (SEL_W)
    ) u_pick (
        .en    (w_hart_en),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state         <= ST_IDLE;
            ret_state     <= ST_RUN;
            flush_pend    <= 1'b0;
            r_hart_sel    <= '0;
            r_sel_valid   <= 1'b0;
            r_switch      <= 1'b0;
            r_flush       <= 1'b0;
            r_stall       <= '1;
            r_quantum_cnt <= '0;
        end else begin
            r_switch   <= 1'b0;
            // A request landing in the same cycle as FLUSH entry stays pending.
            flush_pend <= (|w_flush_req) || (flush_pend && !enter_flush);

            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state         <= ST_RUN;
                        r_hart_sel    <= pick_idx;
                        r_quantum_cnt <= '0;
                        r_sel_valid   <= 1'b1;
                        r_stall       <= run_mask(pick_idx);
                        r_switch      <= (pick_idx != r_hart_sel);
                    end
                end

                ST_RUN: begin
                    r_quantum_cnt <= cnt_inc;
                    if (flush_pend) begin
                        state       <= ST_FLUSH;
                        ret_state   <= ST_RUN;
                        r_sel_valid <= 1'b0;
                        r_stall     <= '1;
                    end else if (expire || !cur_en) begin
                        state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (flush_pend) begin
                        state       <= ST_FLUSH;
                        ret_state   <= ST_DRAIN;
                        r_sel_valid <= 1'b0;
                        r_stall     <= '1;
                    end else if (drain_go) begin
                        if (!pick_found) begin
                            state       <= ST_IDLE;
                            r_sel_valid <= 1'b0;
                            r_stall     <= '1;
                        end else begin
                            // Same hart re-picked (sole candidate): new slice, no switch.
                            state         <= ST_RUN;
                            r_quantum_cnt <= '0;
                            r_hart_sel    <= pick_idx;
                            r_stall       <= run_mask(pick_idx);
                            r_switch      <= (pick_idx != r_hart_sel);
                        end
                    end
                end

                ST_FLUSH: begin
                    if (!r_flush) begin
                        if (!w_mem_busy) begin
                            r_flush <= 1'b1;
                        end
                    end else if (w_flush_done) begin
                        r_flush     <= 1'b0;
                        state       <= ret_state;
                        r_sel_valid <= 1'b1;
                        r_stall     <= run_mask(r_hart_sel);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_hart_scheduler.sv
// Bench for rv_hart_scheduler with N_HARTS=2, QUANTUM=4.
// Each scenario pushes the expected output word for a cycle when it drives
// that cycle's stimulus, then pops and compares it one step after the edge.
module tb_rv_hart_scheduler;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic       CLK = 1'b0;
    logic       RST_X;
    logic [1:0] w_hart_en;
    logic [1:0] w_switch_ok;
    logic       w_mem_busy;
    logic [1:0] w_flush_req;
    logic       w_flush_done;
    logic       r_hart_sel;
    logic       r_sel_valid;
    logic       r_switch;
    logic       r_flush;
    logic [1:0] r_stall;
    logic [2:0] r_quantum_cnt;
    logic [1:0] r_state;

    logic [10:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    rv_hart_scheduler #(
        .N_HARTS (2),
        .QUANTUM (4)
    ) dut (
        .CLK           (CLK),
        .RST_X         (RST_X),
        .w_hart_en     (w_hart_en),
        .w_switch_ok   (w_switch_ok),
        .w_mem_busy    (w_mem_busy),
        .w_flush_req   (w_flush_req),
        .w_flush_done  (w_flush_done),
        .r_hart_sel    (r_hart_sel),
        .r_sel_valid   (r_sel_valid),
        .r_switch      (r_switch),
        .r_flush       (r_flush),
        .r_stall       (r_stall),
        .r_quantum_cnt (r_quantum_cnt),
        .r_state       (r_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] ex(input logic [1:0] st, input logic sel, input logic v,
                                       input logic sw, input logic fl, input logic [1:0] stl,
                                       input logic [2:0] c);
        return {st, sel, v, sw, fl, stl, c};
    endfunction

    function automatic logic [1:0] stall_of(input logic sel);
        return sel ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [10:0] obs_word();
        return {r_state, r_hart_sel, r_sel_valid, r_switch, r_flush, r_stall, r_quantum_cnt};
    endfunction

    function automatic string fmt(input logic [10:0] w);
        return $sformatf("st=%0d sel=%0d valid=%0d switch=%0d flush=%0d stall=%b cnt=%0d",
                         w[10:9], w[8], w[7], w[6], w[5], w[4:3], w[2:0]);
    endfunction

    task automatic test_reset();
        logic [10:0] e, o;
        RST_X        = 1'b0;
        w_hart_en    = 2'b11;
        w_switch_ok  = 2'b11;
        w_mem_busy   = 1'b0;
        w_flush_req  = 2'b00;
        w_flush_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ex(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'd0));
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs_word();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %s, required %s", i, fmt(o), fmt(e));
            end
        end
        @(negedge CLK);
        RST_X = 1'b1;
    endtask

    // Two harts alternate: 4 RUN cycles (cnt 0..3), one DRAIN cycle, switch.
    task automatic test_rotation();
        logic [10:0] e, o;
        for (int i = 0; i < 11; i++) begin
            int   s;
            int   p;
            logic sl;
            s  = i / 5;
            p  = i % 5;
            sl = s[0];
            if (p < 4)
                exp_q.push_back(ex(S_RUN, sl, 1'b1, (p == 0 && s > 0), 1'b0, stall_of(sl), 3'(p)));
            else
                exp_q.push_back(ex(S_DRAIN, sl, 1'b1, 1'b0, 1'b0, stall_of(sl), 3'd4));
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs_word();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got %s, required %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    // Hart 0 not at a safe boundary: DRAIN holds until switch_ok[0] rises.
    task automatic test_drain_hold();
        logic [10:0] e, o;
        for (int i = 0; i < 19; i++) begin
            logic       sl;
            logic       sw;
            logic [1:0] st;
            int         c;
            if (i == 0)  w_switch_ok = 2'b10;
            if (i == 13) w_switch_ok = 2'b11;
            sw = 1'b0;
            if (i <= 2) begin
                st = S_RUN;   sl = 1'b0; c = i + 1;
            end else if (i <= 12) begin
                st = S_DRAIN; sl = 1'b0; c = 4;
            end else if (i <= 16) begin
                st = S_RUN;   sl = 1'b1; c = i - 13; sw = (i == 13);
            end else if (i == 17) begin
                st = S_DRAIN; sl = 1'b1; c = 4;
            end else begin
                st = S_RUN;   sl = 1'b0; c = 0; sw = 1'b1;
            end
            exp_q.push_back(ex(st, sl, 1'b1, sw, 1'b0, stall_of(sl), 3'(c)));
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs_word();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL drain_hold[%0d]: got %s, required %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    // Only hart 0 enabled: expiry restarts the slice, never a switch.
    task automatic test_single_hart();
        logic [10:0] e, o;
        for (int i = 0; i < 15; i++) begin
            int p;
            if (i == 0) w_hart_en = 2'b01;
            p = i % 5;
            if (p < 3)
                exp_q.push_back(ex(S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'(p + 1)));
            else if (p == 3)
                exp_q.push_back(ex(S_DRAIN, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'd4));
            else
                exp_q.push_back(ex(S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'd0));
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs_word();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single_hart[%0d]: got %s, required %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    // Flush held off by mem_busy, stray done ignored, second request queued.
    task automatic test_flush();
        logic [10:0] e, o;
        for (int i = 0; i < 11; i++) begin
            case (i)
                0: begin w_hart_en = 2'b11; w_mem_busy = 1'b1; w_flush_req = 2'b10; end
                1: w_flush_req = 2'b00;
                2: w_flush_done = 1'b1;
                3: begin w_flush_done = 1'b0; w_mem_busy = 1'b0; end
                4: w_flush_req = 2'b01;
                5: begin w_flush_req = 2'b00; w_flush_done = 1'b1; end
                6: w_flush_done = 1'b0;
                8: w_flush_done = 1'b1;
                9: w_flush_done = 1'b0;
                default: ;
            endcase
            case (i)
                0:       exp_q.push_back(ex(S_RUN,   1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'd1));
                1, 2:    exp_q.push_back(ex(S_FLUSH, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'd2));
                3, 4:    exp_q.push_back(ex(S_FLUSH, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'd2));
                5:       exp_q.push_back(ex(S_RUN,   1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'd2));
                6:       exp_q.push_back(ex(S_FLUSH, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'd3));
                7:       exp_q.push_back(ex(S_FLUSH, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'd3));
                8:       exp_q.push_back(ex(S_RUN,   1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'd3));
                9:       exp_q.push_back(ex(S_DRAIN, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'd4));
                default: exp_q.push_back(ex(S_RUN,   1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 3'd0));
            endcase
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs_word();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL flush[%0d]: got %s, required %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    // All harts disabled -> IDLE; re-enable hart 1 -> RUN with switch pulse.
    task automatic test_idle();
        logic [10:0] e, o;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) w_hart_en = 2'b00;
            if (i == 8) w_hart_en = 2'b10;
            case (i)
                0, 1, 2: exp_q.push_back(ex(S_RUN,   1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'(i + 1)));
                3:       exp_q.push_back(ex(S_DRAIN, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'd4));
                4:       exp_q.push_back(ex(S_RUN,   1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'd0));
                5:       exp_q.push_back(ex(S_DRAIN, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'd1));
                6, 7:    exp_q.push_back(ex(S_IDLE,  1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'd1));
                8:       exp_q.push_back(ex(S_RUN,   1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 3'd0));
                default: exp_q.push_back(ex(S_RUN,   1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'd1));
            endcase
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs_word();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL idle[%0d]: got %s, required %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    // Reset asserted while r_flush is high must clear outputs without an edge.
    task automatic test_async_reset();
        logic [10:0] e, o;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) w_flush_req = 2'b01;
            if (i == 1) w_flush_req = 2'b00;
            case (i)
                0:       exp_q.push_back(ex(S_RUN,   1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'd2));
                1:       exp_q.push_back(ex(S_FLUSH, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 3'd3));
                default: exp_q.push_back(ex(S_FLUSH, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 3'd3));
            endcase
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs_word();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL async_reset_pre[%0d]: got %s, required %s", i, fmt(o), fmt(e));
            end
        end

        #2;
        RST_X = 1'b0;
        exp_q.push_back(ex(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'd0));
        #1;
        e = exp_q.pop_front();
        o = obs_word();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %s, required %s", fmt(o), fmt(e));
        end

        exp_q.push_back(ex(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'd0));
        @(posedge CLK); #1;
        e = exp_q.pop_front();
        o = obs_word();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL async_reset_held: got %s, required %s", fmt(o), fmt(e));
        end

        @(negedge CLK);
        RST_X = 1'b1;
        // Pending flush was discarded by reset: plain RUN follows, no FLUSH.
        for (int i = 0; i < 2; i++) begin
            if (i == 0)
                exp_q.push_back(ex(S_RUN, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 3'd0));
            else
                exp_q.push_back(ex(S_RUN, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'd1));
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs_word();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL async_reset_post[%0d]: got %s, required %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_drain_hold();
        test_single_hart();
        test_flush();
        test_idle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
